// File: rtl/starfield_mixer_if.sv
// Pixel, compositing and CPU-write signals of the starfield mixer.
// The slave modport is the mixer's view of the bus.
interface starfield_mixer_if;
    logic        en;
    logic        vblank;
    logic        hblank;
    logic        sf_on;
    logic [7:0]  sf_star;
    logic        fg_on;
    logic [23:0] fg_rgb;
    logic [2:0]  addr;
    logic [7:0]  data_in;
    logic        write;
    logic [23:0] rgb_out;
    logic        blank_out;
    logic        fade_busy;

    modport slave (
        input  en, vblank, hblank, sf_on, sf_star, fg_on, fg_rgb, addr, data_in, write,
        output rgb_out, blank_out, fade_busy
    );
    modport master (
        output en, vblank, hblank, sf_on, sf_star, fg_on, fg_rgb, addr, data_in, write,
        input  rgb_out, blank_out, fade_busy
    );
endinterface

// File: rtl/starfield_mixer.sv
// Starfield compositing stage: frame-stepped fade, RGB tint, opaque foreground overlay.
// Two en-gated pipeline stages from sf_star to rgb_out.
module starfield_mixer #(
    parameter logic [7:0]  STEP_RST = 8'd4,
    parameter logic [23:0] TINT_RST = 24'hFFFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    starfield_mixer_if.slave     bus
);
    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_RISE = 2'd1;
    localparam logic [1:0] S_FALL = 2'd2;

    logic            r_enable;
    logic [7:0]      r_level;
    logic [7:0]      r_step;
    logic [1:0]      r_state;
    logic [2:0][7:0] r_tint;
    logic            r_vb_d;

    logic            w_vb_rise;
    logic            w_wr0;
    logic [8:0]      w_sum;
    logic [8:0]      w_diff;

    assign w_vb_rise = bus.vblank & ~r_vb_d;
    assign w_wr0     = bus.write && (bus.addr == 3'd0);
    assign w_sum     = {1'b0, r_level} + {1'b0, r_step};
    assign w_diff    = {1'b0, r_level} - {1'b0, r_step};

    // Control registers and fade FSM; an addr0 write pre-empts a coincident vblank step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable <= 1'b0;
            r_level  <= 8'd0;
            r_step   <= STEP_RST;
            r_state  <= S_HOLD;
            r_tint   <= TINT_RST;
            r_vb_d   <= 1'b0;
        end else begin
            r_vb_d <= bus.vblank;
            if (bus.write) begin
                case (bus.addr)
                    3'd0:    r_enable  <= bus.data_in[0];
                    3'd1:    r_step    <= bus.data_in;
                    3'd2:    r_tint[2] <= bus.data_in;
                    3'd3:    r_tint[1] <= bus.data_in;
                    3'd4:    r_tint[0] <= bus.data_in;
                    default: ;
                endcase
            end
            if (w_wr0) begin
                if (bus.data_in[2]) begin
                    r_level <= bus.data_in[1] ? 8'd255 : 8'd0;
                    r_state <= S_HOLD;
                end else if (bus.data_in[1]) begin
                    r_state <= (r_level == 8'd255) ? S_HOLD : S_RISE;
                end else begin
                    r_state <= (r_level == 8'd0) ? S_HOLD : S_FALL;
                end
            end else if (w_vb_rise) begin
                case (r_state)
                    S_RISE: begin
                        if (w_sum >= 9'd255) begin
                            r_level <= 8'd255;
                            r_state <= S_HOLD;
                        end else begin
                            r_level <= w_sum[7:0];
                        end
                    end
                    S_FALL: begin
                        if (w_diff[8] || (w_diff[7:0] == 8'd0)) begin
                            r_level <= 8'd0;
                            r_state <= S_HOLD;
                        end else begin
                            r_level <= w_diff[7:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.fade_busy = (r_state != S_HOLD);

    logic            r_vis1;
    logic [7:0]      r_b1;
    logic            r_fg_on1;
    logic [23:0]     r_fg_rgb1;
    logic            r_blank1;
    logic [23:0]     r_rgb2;
    logic            r_blank2;
    logic            w_blank_in;
    logic [7:0]      w_b1;
    logic [8:0]      w_lvl_p1;
    logic [2:0][7:0] w_star_rgb;

    assign w_blank_in = bus.hblank | bus.vblank;
    assign w_lvl_p1   = {1'b0, r_level} + 9'd1;
    assign w_b1       = 8'(({8'd0, bus.sf_star} * {7'd0, w_lvl_p1}) >> 8);

    // (x * (t+1)) >> 8 keeps full-scale tint/level as an exact pass-through.
    genvar c;
    generate
        for (c = 0; c < 3; c++) begin : g_ch
            logic [8:0] w_tint_p1;
            assign w_tint_p1     = {1'b0, r_tint[c]} + 9'd1;
            assign w_star_rgb[c] = 8'(({8'd0, r_b1} * {7'd0, w_tint_p1}) >> 8);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vis1    <= 1'b0;
            r_b1      <= 8'd0;
            r_fg_on1  <= 1'b0;
            r_fg_rgb1 <= 24'd0;
            r_blank1  <= 1'b0;
            r_rgb2    <= 24'd0;
            r_blank2  <= 1'b0;
        end else if (bus.en) begin
            r_vis1    <= bus.sf_on & r_enable & ~w_blank_in;
            r_b1      <= w_b1;
            r_fg_on1  <= bus.fg_on;
            r_fg_rgb1 <= bus.fg_rgb;
            r_blank1  <= w_blank_in;
            r_blank2  <= r_blank1;
            if (r_blank1)      r_rgb2 <= 24'd0;
            else if (r_fg_on1) r_rgb2 <= r_fg_rgb1;
            else if (r_vis1)   r_rgb2 <= w_star_rgb;
            else               r_rgb2 <= 24'd0;
        end
    end

    assign bus.rgb_out   = r_rgb2;
    assign bus.blank_out = r_blank2;
endmodule

// File: tb/tb_starfield_mixer.sv
// Directed bench for starfield_mixer: fade FSM, tint, overlay, pipeline timing, async reset.
module tb_starfield_mixer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    starfield_mixer_if bus ();

    starfield_mixer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.write   = 1'b1;
        bus.addr    = a;
        bus.data_in = d;
        tick();
        bus.write   = 1'b0;
    endtask

    task automatic vb_pulse();
        bus.vblank = 1'b1;
        tick();
        bus.vblank = 1'b0;
        tick();
    endtask

    // With sf_star=FF and white tint, rgb_out equals {level,level,level}.
    task automatic flush();
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.rgb_out !== 24'h0 || bus.blank_out !== 1'b0 || bus.fade_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: rgb=%h blank=%b busy=%b, want 000000 0 0",
                     bus.rgb_out, bus.blank_out, bus.fade_busy);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_instant_in();
        wr(3'd0, 8'h07);
        bus.sf_on   = 1'b1;
        bus.sf_star = 8'h80;
        bus.en      = 1'b1;
        tick(); tick();
        checks++;
        if (bus.rgb_out !== 24'h808080) begin
            failures++;
            $display("FAIL instant_in_rgb: got %h want 808080", bus.rgb_out);
        end
        checks++;
        if (bus.fade_busy !== 1'b0) begin
            failures++;
            $display("FAIL instant_in_busy: got %b want 0", bus.fade_busy);
        end
    endtask

    task automatic test_fade_in();
        logic [7:0] exp_l [3];
        exp_l = '{8'd100, 8'd200, 8'd255};
        bus.sf_star = 8'hFF;
        wr(3'd0, 8'h05);
        wr(3'd1, 8'd100);
        wr(3'd0, 8'h03);
        checks++;
        if (bus.fade_busy !== 1'b1) begin
            failures++;
            $display("FAIL fade_in_start_busy: got %b want 1", bus.fade_busy);
        end
        for (int i = 0; i < 3; i++) begin
            vb_pulse();
            flush();
            checks++;
            if (bus.rgb_out !== {3{exp_l[i]}}) begin
                failures++;
                $display("FAIL fade_in_level%0d: got %h want %h", i, bus.rgb_out, {3{exp_l[i]}});
            end
            checks++;
            if (bus.fade_busy !== (i < 2)) begin
                failures++;
                $display("FAIL fade_in_busy%0d: got %b want %b", i, bus.fade_busy, (i < 2));
            end
        end
    endtask

    task automatic test_step_zero_and_out();
        wr(3'd1, 8'd0);
        wr(3'd0, 8'h01);
        for (int i = 0; i < 5; i++) vb_pulse();
        flush();
        checks++;
        if (bus.rgb_out !== 24'hFFFFFF || bus.fade_busy !== 1'b1) begin
            failures++;
            $display("FAIL step_zero_freeze: rgb=%h busy=%b want FFFFFF 1", bus.rgb_out, bus.fade_busy);
        end
        wr(3'd1, 8'd255);
        vb_pulse();
        flush();
        checks++;
        if (bus.rgb_out !== 24'h000000 || bus.fade_busy !== 1'b0) begin
            failures++;
            $display("FAIL fade_out_full: rgb=%h busy=%b want 000000 0", bus.rgb_out, bus.fade_busy);
        end
    endtask

    task automatic test_tint_overlay();
        wr(3'd0, 8'h07);
        wr(3'd2, 8'hFF);
        wr(3'd3, 8'h7F);
        wr(3'd4, 8'h00);
        flush();
        checks++;
        if (bus.rgb_out !== 24'hFF7F00) begin
            failures++;
            $display("FAIL tint_rgb: got %h want FF7F00", bus.rgb_out);
        end
        bus.fg_on  = 1'b1;
        bus.fg_rgb = 24'h123456;
        tick(); tick();
        checks++;
        if (bus.rgb_out !== 24'h123456) begin
            failures++;
            $display("FAIL fg_overlay: got %h want 123456", bus.rgb_out);
        end
        bus.hblank = 1'b1;
        tick(); tick();
        checks++;
        if (bus.rgb_out !== 24'h000000 || bus.blank_out !== 1'b1) begin
            failures++;
            $display("FAIL hblank: rgb=%h blank=%b want 000000 1", bus.rgb_out, bus.blank_out);
        end
        bus.hblank = 1'b0;
        bus.fg_on  = 1'b0;
        wr(3'd3, 8'hFF);
        wr(3'd4, 8'hFF);
        flush();
    endtask

    task automatic test_back_to_back();
        logic [7:0] v [5];
        logic [23:0] held;
        v = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        for (int i = 0; i < 5; i++) begin
            bus.sf_star = v[i];
            tick();
            if (i >= 1) begin
                checks++;
                if (bus.rgb_out !== {3{v[i-1]}}) begin
                    failures++;
                    $display("FAIL b2b_%0d: got %h want %h", i, bus.rgb_out, {3{v[i-1]}});
                end
            end
        end
        held = {3{v[3]}};
        bus.en      = 1'b0;
        bus.sf_star = 8'h99;
        tick(); tick(); tick();
        checks++;
        if (bus.rgb_out !== held) begin
            failures++;
            $display("FAIL en_hold: got %h want %h", bus.rgb_out, held);
        end
        bus.en = 1'b1;
        tick();
        checks++;
        if (bus.rgb_out !== 24'h505050) begin
            failures++;
            $display("FAIL en_resume: got %h want 505050", bus.rgb_out);
        end
        bus.sf_star = 8'hFF;
        flush();
    endtask

    task automatic test_write_vs_vblank();
        wr(3'd0, 8'h05);
        wr(3'd1, 8'd10);
        wr(3'd0, 8'h03);
        vb_pulse();
        wr(3'd1, 8'd4);
        bus.vblank  = 1'b1;
        bus.write   = 1'b1;
        bus.addr    = 3'd0;
        bus.data_in = 8'h03;
        tick();
        bus.write  = 1'b0;
        bus.vblank = 1'b0;
        tick();
        flush();
        checks++;
        if (bus.rgb_out !== 24'h0A0A0A) begin
            failures++;
            $display("FAIL write_wins: got %h want 0A0A0A", bus.rgb_out);
        end
        vb_pulse();
        flush();
        checks++;
        if (bus.rgb_out !== 24'h0E0E0E || bus.fade_busy !== 1'b1) begin
            failures++;
            $display("FAIL next_frame_step: rgb=%h busy=%b want 0E0E0E 1", bus.rgb_out, bus.fade_busy);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rgb_out !== 24'h0 || bus.fade_busy !== 1'b0 || dut.r_level !== 8'd0) begin
            failures++;
            $display("FAIL async_reset: rgb=%h busy=%b level=%h want 000000 0 00",
                     bus.rgb_out, bus.fade_busy, dut.r_level);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        bus.en = 1'b0; bus.vblank = 1'b0; bus.hblank = 1'b0;
        bus.sf_on = 1'b0; bus.sf_star = 8'h00; bus.fg_on = 1'b0; bus.fg_rgb = 24'h0;
        bus.addr = 3'd0; bus.data_in = 8'h00; bus.write = 1'b0;
        test_reset();
        test_instant_in();
        test_fade_in();
        test_step_zero_and_out();
        test_tint_overlay();
        test_back_to_back();
        test_write_vs_vblank();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
